// File: rtl/uart_transmitter_receiver.sv
// 8N1 UART: independent transmitter and receiver halves sharing only clock and reset.
// The receiver double-synchronises rx and samples at bit centres counted from the start-bit edge.
module uart_transmitter_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       transmit,
  input  logic [7:0] in,
  output logic       busy,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] out,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rxs_q, rxs_d;
  logic [7:0]      out_q, out_d;
  logic            done_q, done_d;

  // The byte is latched into a private shift register so later changes on in cannot reach the line.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (transmit) begin
          tx_shift_d = in;
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_d       = 1'b1;
          busy_d     = 1'b0;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // Half a bit after the falling edge we are at the start-bit centre; every later sample is a whole bit on.
  always_comb begin
    rx_meta_d  = rx;
    rxs_d      = rx_meta_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    out_d      = out_q;
    done_d     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxs_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rxs_q) begin
            out_d      = rx_shift_q;
            done_d     = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_WAIT_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_WAIT_IDLE: begin
        if (rxs_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      out_q      <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rxs_q      <= rxs_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      out_q      <= out_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_transmitter_receiver.sv
// Scoreboard bench for the UART pair: stimulus pushes expected bytes, a monitor pops them on done.
// The tx line is checked against the 8N1 frame rule, and rx is driven directly for error and baud cases.
module tb_uart_transmitter_receiver;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       transmit = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy;
  logic       tx;
  logic       rx;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b1;
  logic [7:0] dout;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_expected = 8'h00;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_transmitter_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .transmit(transmit),
    .in(din),
    .busy(busy),
    .tx(tx),
    .rx(rx),
    .out(dout),
    .done(done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Line level of bit j of an 8N1 frame: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // Every done must match the oldest outstanding expected byte.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      checkOutput("pending_at_done", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        last_expected = exp_q.pop_front();
        checkOutput("rx_byte", {24'd0, dout}, {24'd0, last_expected});
      end
    end
  end

  // Loopback send of one byte, checking every bit centre on tx and the busy length.
  task automatic applyStimulus(input logic [7:0] b);
    int busy_cycles = 0;
    @(negedge clk);
    din = b;
    transmit = 1'b1;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    transmit = 1'b0;
    din = 8'($urandom);
    for (int n = 0; n < 12 * C; n++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cycles++;
      if (n % C == C / 2)
        checkOutput($sformatf("tx_bit%0d_of_%02h", n / C, b), {31'd0, tx}, {31'd0, frame_bit(b, n / C)});
    end
    checkOutput("busy_cycles", busy_cycles, 10 * C);
  endtask

  // Drives a frame on rx with an arbitrary bit time, starting just before a clock edge.
  task automatic driveRxFrame(input logic [7:0] b, input logic stop_bit, input int bit_time);
    @(posedge clk);
    #9;
    for (int j = 0; j < 10; j++) begin
      rx_drv = (j == 9) ? stop_bit : frame_bit(b, j);
      #(bit_time);
    end
    rx_drv = 1'b1;
  endtask

  task automatic drainCheck(input string name);
    for (int n = 0; n < 20 * C; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int saved;
    int rises;
    int low_run;
    int high_cnt;
    logic prev_busy;
    logic [7:0] b;

    // Reset state, held and then released with no stimulus
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_out", {24'd0, dout}, 32'h00);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post_reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("post_reset_out", {24'd0, dout}, 32'h00);
    checkOutput("post_reset_done_count", done_count, 0);

    // Loopback: directed A5, then random bytes
    applyStimulus(8'hA5);
    drainCheck("drain_a5");
    for (int i = 0; i < 8; i++) applyStimulus(8'($urandom));
    drainCheck("drain_random_loop");

    // Back-to-back frames with transmit held high
    @(negedge clk);
    din = 8'h00;
    transmit = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    rises = 0;
    low_run = 0;
    prev_busy = 1'b0;
    for (int n = 0; n < 35 * C; n++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        rises++;
        if (rises >= 2) begin
          checkOutput($sformatf("b2b_gap_%0d", rises - 1), low_run, 1);
          low_run = 0;
        end
        if (rises == 1) din = 8'hFF;
        if (rises == 2) din = 8'h55;
        if (rises == 3) transmit = 1'b0;
      end
      if (!busy && rises >= 1 && rises < 3) low_run++;
      prev_busy = busy;
      if (rises == 3 && !busy) break;
    end
    checkOutput("b2b_frames", rises, 3);
    drainCheck("drain_b2b");

    // Busy guard: a request mid-frame is ignored
    @(negedge clk);
    din = 8'h3C;
    transmit = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    transmit = 1'b0;
    repeat (3 * C) @(negedge clk);
    din = 8'hC3;
    transmit = 1'b1;
    repeat (2) @(negedge clk);
    transmit = 1'b0;
    for (int n = 0; n < 12 * C; n++) begin
      if (!busy) break;
      @(negedge clk);
    end
    high_cnt = 0;
    for (int n = 0; n < 3 * C; n++) begin
      @(negedge clk);
      if (busy) high_cnt++;
    end
    checkOutput("guard_no_second_frame", high_cnt, 0);
    drainCheck("drain_guard");

    // Receiver driven directly: short glitch is a false start
    loop_en = 1'b0;
    saved = done_count;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (C / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * C) @(negedge clk);
    checkOutput("glitch_no_done", done_count, saved);
    checkOutput("glitch_out_held", {24'd0, dout}, {24'd0, last_expected});

    // Framing error: stop bit 0, line then held low a while before recovering
    saved = done_count;
    driveRxFrame(8'h81, 1'b0, 10 * C);
    rx_drv = 1'b0;
    repeat (2 * C) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4 * C) @(negedge clk);
    checkOutput("framing_no_done", done_count, saved);
    checkOutput("framing_out_held", {24'd0, dout}, {24'd0, last_expected});
    exp_q.push_back(8'h7E);
    driveRxFrame(8'h7E, 1'b1, 10 * C);
    drainCheck("drain_recovery");

    // Random frames back to back at nominal rate, then +5% and -5% bit times
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      driveRxFrame(b, 1'b1, 10 * C);
    end
    b = 8'($urandom);
    exp_q.push_back(b);
    driveRxFrame(b, 1'b1, 168);
    b = 8'($urandom);
    exp_q.push_back(b);
    driveRxFrame(b, 1'b1, 152);
    drainCheck("drain_direct_rx");
    repeat (2 * C) @(negedge clk);

    // Reset in the middle of data bit 4 of an F0 loopback frame
    loop_en = 1'b1;
    saved = done_count;
    @(negedge clk);
    din = 8'hF0;
    transmit = 1'b1;
    @(posedge clk);
    #1;
    transmit = 1'b0;
    repeat (5 * C + 8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_tx", {31'd0, tx}, 32'd1);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    last_expected = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * C) @(negedge clk);
    checkOutput("midreset_no_done", done_count, saved);
    checkOutput("midreset_out", {24'd0, dout}, 32'h00);
    applyStimulus(8'h0F);
    drainCheck("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
